// File: rtl/dev_bridge_timer.sv
// dev_bridge_timer: device-window countdown timer with interrupt, beside the M-stage data memory.
// Define BRIDGE_PARTIAL_WR_EN to accept byte-lane (sb/sh) writes to CTRL and PRESET.
module dev_bridge_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  input  logic        we,
  output logic        dev_hit,
  output logic [31:0] dev_rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;
  state_e             state_q, state_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d, count_q, count_d;
  logic               irq_pend_q, irq_pend_d;
  logic               wr, ctrl_wr, preset_wr;
  logic [31:0]        wmask, preset_new;
  assign dev_hit = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
`ifdef BRIDGE_PARTIAL_WR_EN
  assign wr      = we & dev_hit;
  assign wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign ctrl_wr = wr & (addr[3:2] == 2'b00) & be[0];
`else
  assign wr      = we & dev_hit & (be == 4'b1111);
  assign wmask   = '1;
  assign ctrl_wr = wr & (addr[3:2] == 2'b00);
`endif
  assign preset_wr  = wr & (addr[3:2] == 2'b01);
  assign preset_new = (32'(preset_q) & ~wmask) | (wd & wmask);
  assign dev_rdata  = !dev_hit              ? '0 :
                      addr[3:2] == 2'b00    ? {28'b0, ctrl_q} :
                      addr[3:2] == 2'b01    ? 32'(preset_q) : 32'(count_q);
  assign irq = irq_pend_q & ctrl_q[3];
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;
    preset_d   = preset_wr ? CNT_W'(preset_new) : preset_q;
    case (state_q)
      IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT:
        if (!ctrl_q[0]) state_d = IDLE;
        else if (count_q <= CNT_W'(1)) begin
          count_d    = '0;
          irq_pend_d = 1'b1;
          state_d    = INT;
        end else count_d = count_q - CNT_W'(1);
      INT:
        if (ctrl_q[2:1] == 2'b01) begin
          irq_pend_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      default: state_d = IDLE;
    endcase
    // A bus write to CTRL overrides the FSM's own EN clear and drops any pending interrupt.
    if (ctrl_wr) begin
      ctrl_d     = wd[3:0];
      irq_pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end
endmodule

// File: tb/tb_dev_bridge_timer.sv
// tb_dev_bridge_timer: directed self-checking bench for dev_bridge_timer.
module tb_dev_bridge_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [3:0]  be = '0;
  logic        we = 1'b0;
  logic        dev_hit;
  logic [31:0] dev_rdata;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  localparam logic [31:0] A_CTRL = 32'h7F00, A_PRE = 32'h7F04, A_CNT = 32'h7F08;
  dev_bridge_timer dut (
    .clk(clk), .reset(reset), .addr(addr), .wd(wd), .be(be), .we(we),
    .dev_hit(dev_hit), .dev_rdata(dev_rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'b1111);
    @(negedge clk);
    addr = a;
    wd   = d;
    be   = b;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dev_rdata, exp);
  endtask
  int c3[11] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
  int i3[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  initial begin
    tick(3);
    @(negedge clk);
    reset = 1'b1;
    tick();
    rd("t1.ctrl", A_CTRL, 0);
    check("t1.hit0", dev_hit, 1);
    rd("t1.pre", A_PRE, 0);
    check("t1.hit4", dev_hit, 1);
    rd("t1.cnt", A_CNT, 0);
    check("t1.hit8", dev_hit, 1);
    rd("t1.rsv", 32'h7F0C, 0);
    check("t1.hitC", dev_hit, 0);
    check("t1.irq", irq, 0);
    addr = 32'h7F10;
    #1 check("t1.hit10", dev_hit, 0);
    addr = 32'h7EFC;
    #1 check("t1.hit_below", dev_hit, 0);
    // one-shot, PRESET=5
    sw(A_PRE, 5);
    rd("t1.pre_lo_ignored", 32'h7F07, 5);
    sw(A_CTRL, 32'h9);
    rd("t2.ctrl", A_CTRL, 9);
    tick(2);
    rd("t2.cnt_e2", A_CNT, 5);
    check("t2.irq_e2", irq, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      rd($sformatf("t2.cnt_e%0d", k + 2), A_CNT, 5 - k);
      check($sformatf("t2.irq_e%0d", k + 2), irq, 0);
    end
    tick();
    rd("t2.cnt_e7", A_CNT, 0);
    check("t2.irq_e7", irq, 1);
    tick();
    rd("t2.ctrl_e8", A_CTRL, 8);
    check("t2.irq_e8", irq, 1);
    tick(3);
    check("t2.irq_sticky", irq, 1);
    sw(A_CNT, 123);
    rd("t2.cnt_ro", A_CNT, 0);
    check("t2.irq_after_cnt_wr", irq, 1);
    sw(A_CTRL, 32'h8);
    check("t2.irq_cleared", irq, 0);
    // auto-reload, PRESET=3
    sw(A_PRE, 3);
    sw(A_CTRL, 32'hB);
    for (int k = 0; k < 11; k++) begin
      tick();
      rd($sformatf("t3.cnt_%0d", k + 1), A_CNT, c3[k]);
      check($sformatf("t3.irq_%0d", k + 1), irq, i3[k]);
    end
    sw(A_CTRL, 0);
    tick();
    // stop mid-count, PRESET change mid-count, no resume
    sw(A_PRE, 20);
    sw(A_CTRL, 32'h1);
    tick(5);
    rd("t4.cnt_e5", A_CNT, 17);
    sw(A_PRE, 7);
    rd("t4.cnt_e6", A_CNT, 16);
    tick(6);
    rd("t4.cnt_e12", A_CNT, 10);
    sw(A_CTRL, 0);
    rd("t4.cnt_stop", A_CNT, 9);
    tick(2);
    rd("t4.cnt_frozen", A_CNT, 9);
    sw(A_CTRL, 32'h1);
    tick(2);
    rd("t4.cnt_reload", A_CNT, 7);
    sw(A_CTRL, 0);
    tick();
    rd("t4.cnt_hold6", A_CNT, 6);
    // PRESET=0, IM=0
    sw(A_PRE, 0);
    sw(A_CTRL, 32'h1);
    tick();
    rd("t5.cnt_load", A_CNT, 6);
    tick();
    rd("t5.cnt_zero", A_CNT, 0);
    tick();
    check("t5.irq_masked", irq, 0);
    tick();
    rd("t5.ctrl_en_clr", A_CTRL, 0);
    sw(A_CTRL, 32'h8);
    check("t5.irq_after_im", irq, 0);
    // CTRL write colliding with INT's EN clear; MODE=1x acts as one-shot
    sw(A_PRE, 2);
    sw(A_CTRL, 32'h9);
    tick(4);
    check("tc.irq_int", irq, 1);
    rd("tc.cnt_int", A_CNT, 0);
    sw(A_CTRL, 32'hD);
    rd("tc.ctrl_bus_wins", A_CTRL, 32'hD);
    check("tc.irq_cleared", irq, 0);
    tick(2);
    rd("tc.cnt_reload", A_CNT, 2);
    tick(2);
    check("tc.irq_mode2", irq, 1);
    tick();
    rd("tc.ctrl_mode2_oneshot", A_CTRL, 32'hC);
    check("tc.irq_mode2_sticky", irq, 1);
    sw(A_CTRL, 0);
    check("tc.irq_off", irq, 0);
    // byte-lane writes
    sw(A_PRE, 0);
    sw(A_PRE, 32'h1234_56AA, 4'b0001);
`ifdef BRIDGE_PARTIAL_WR_EN
    rd("t6.sb_pre", A_PRE, 32'h0000_00AA);
`else
    rd("t6.sb_pre", A_PRE, 0);
`endif
    sw(A_PRE, 32'hBEEF_0000, 4'b1100);
`ifdef BRIDGE_PARTIAL_WR_EN
    rd("t6.sh_pre", A_PRE, 32'hBEEF_00AA);
`else
    rd("t6.sh_pre", A_PRE, 0);
`endif
    sw(A_CTRL, 32'h0000_0F0F, 4'b0010);
    rd("t6.sb_ctrl_b1", A_CTRL, 0);
    // asynchronous reset mid-count
    sw(A_PRE, 50);
    sw(A_CTRL, 32'h9);
    tick(5);
    rd("t6.cnt_mid", A_CNT, 47);
    reset = 1'b0;
    rd("t6.rst_cnt", A_CNT, 0);
    rd("t6.rst_ctrl", A_CTRL, 0);
    rd("t6.rst_pre", A_PRE, 0);
    check("t6.rst_irq", irq, 0);
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(10);
    check("t6.post_rst_irq", irq, 0);
    rd("t6.post_rst_cnt", A_CNT, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
